// File: rtl/conv_sched_pkg.sv
// Shared types and elaboration helpers for the convolutional layer frame scheduler.
package conv_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } conv_sched_state_t;

  // Windows per image dimension for a square image and filter.
  function automatic int out_dim(input int image, input int filter, input int stride);
    return (image - filter) / stride + 1;
  endfunction

  // Bits needed to hold every value from 0 up to and including max_count.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/frame_counter.sv
// Saturating up-counter with synchronous clear, count enable and terminal flag.
module frame_counter
  import conv_sched_pkg::*;
#(
  parameter int MAX_COUNT = 16,
  parameter int WIDTH     = cnt_width(MAX_COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  assign terminal = (count == WIDTH'(MAX_COUNT));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !terminal) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/conv_layer_scheduler.sv
// Frame sequencer for one convolutional layer: input handshake, layer clock enable, output
// handshake with backpressure and frame completion. Define CONV_SCHED_PERF_EN for stall_cycles.
module conv_layer_scheduler
  import conv_sched_pkg::*;
#(
  parameter int IMAGE_SIZE  = 28,
  parameter int FILTER_SIZE = 3,
  parameter int STRIDE      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        layer_en,
  input  logic        layer_valid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam int OUT_SIZE  = out_dim(IMAGE_SIZE, FILTER_SIZE, STRIDE);
  localparam int PIX_TOTAL = IMAGE_SIZE * IMAGE_SIZE;
  localparam int OUT_TOTAL = OUT_SIZE * OUT_SIZE;
  localparam int PIX_W     = cnt_width(PIX_TOTAL);
  localparam int OUT_W     = cnt_width(OUT_TOTAL);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_STREAM = ST_STREAM;
  localparam logic [1:0] S_DRAIN  = ST_DRAIN;
  localparam logic [1:0] S_DONE   = ST_DONE;

  if ((IMAGE_SIZE - FILTER_SIZE) % STRIDE != 0) begin : g_bad_stride
    $error("conv_layer_scheduler: IMAGE_SIZE-FILTER_SIZE must be a multiple of STRIDE");
  end

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             fresh;
  logic             frame_start;
  logic             out_hs;
  logic [PIX_W-1:0] pix_count;
  logic             pix_terminal;
  logic [OUT_W-1:0] out_count;
  logic             out_terminal;
  logic             pix_last;
  logic             out_last;

  assign frame_start = (state == S_IDLE) && start;
  assign busy        = (state == S_STREAM) || (state == S_DRAIN);
  assign done        = (state == S_DONE);
  assign out_valid   = layer_valid && fresh && busy;
  assign out_hs      = out_valid && out_ready;
  // The layer only advances when any pending result is being taken this same edge.
  assign in_ready    = (state == S_STREAM) && (!out_valid || out_ready);
  assign layer_en    = in_valid && in_ready;
  assign pix_last    = (pix_count == PIX_W'(PIX_TOTAL - 1));
  assign out_last    = (out_count == OUT_W'(OUT_TOTAL - 1));

  frame_counter #(.MAX_COUNT(PIX_TOTAL), .WIDTH(PIX_W)) u_pix_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (frame_start),
    .en       (layer_en),
    .count    (pix_count),
    .terminal (pix_terminal)
  );

  frame_counter #(.MAX_COUNT(OUT_TOTAL), .WIDTH(OUT_W)) u_out_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (frame_start),
    .en       (out_hs),
    .count    (out_count),
    .terminal (out_terminal)
  );

  // A layer advance marks the new result unseen; it outranks a same-edge handshake clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fresh <= 1'b0;
    end else if (layer_en) begin
      fresh <= 1'b1;
    end else if (out_hs || frame_start) begin
      fresh <= 1'b0;
    end
  end

  // NOTE: state_nxt defaults to state before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_STREAM;
      S_STREAM: if ((layer_en && pix_last) || pix_terminal) state_nxt = S_DRAIN;
      S_DRAIN:  if (out_terminal || (out_hs && out_last)) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

`ifdef CONV_SCHED_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (frame_start) begin
      stall_cycles <= '0;
    end else if (busy && out_valid && !out_ready) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/conv_layer_scheduler.md
# conv_layer_scheduler

Frame-level sequencer for one convolutional layer. Accepts a pixel stream from upstream over a valid/ready handshake and gates the layer's `clk_en` so the line buffers, line buffer controller and inner product units advance only when a pixel is consumed. Presents the layer's combinational result to downstream over a valid/ready handshake with backpressure. Counts pixels in and windows out per frame, then signals frame completion. Sits between the previous layer or input DMA and the next layer.

## Interface
- `IMAGE_SIZE`, 28: image width and height in pixels; square images only.
- `FILTER_SIZE`, 3: filter width and height.
- `STRIDE`, 1: window stride. Legality rule: (IMAGE_SIZE−FILTER_SIZE) % STRIDE == 0; a violation is an elaboration `$error`.
- `OUT_SIZE`, derived, not overridable: (IMAGE_SIZE−FILTER_SIZE)/STRIDE+1.
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: one-cycle pulse; arms a frame. Honoured in IDLE only.
- `in_valid` in 1: upstream pixel present.
- `in_ready` out 1: pixel accepted on the rising edge where `in_valid && in_ready`.
- `layer_en` out 1: drives the convolutional layer `clk_en`.
- `layer_valid` in 1: the layer's `valid`. A level that describes the current `output_data`; it changes only after a `layer_en` edge.
- `out_valid` out 1: fresh layer result available downstream.
- `out_ready` in 1: downstream accepts the result.
- `busy` out 1: high in STREAM and DRAIN.
- `done` out 1: one-cycle pulse at frame end.

## Operation
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE: `start` loads the pixel counter and output counter with 0 and moves to STREAM. `in_ready`=0 and `layer_en`=0 in IDLE.
- `fresh` flag: set on the cycle after any `layer_en`=1; cleared on an output handshake (`out_valid && out_ready`). If a set and a clear fall in the same cycle, the set wins.
- `out_valid` = `layer_valid && fresh && busy`.
- STREAM:
  - `in_ready` = `!out_valid || out_ready`.
  - `layer_en` = `in_valid && in_ready`, combinational. An accepted pixel and the layer advance share the same edge.
  - The pixel counter increments on each accepted pixel. When pixel IMAGE_SIZE² is accepted, go to DRAIN.
- DRAIN: `in_ready`=0 and `layer_en`=0. Wait until the output counter reaches OUT_SIZE², then go to DONE.
- Output counter: increments on each output handshake in STREAM or DRAIN.
- DONE: `done`=1 for exactly one cycle, then return to IDLE. A `start` pulse in DONE is ignored.
- A result is never overwritten before downstream accepts it. This holds because `layer_en` requires `!out_valid || out_ready`.
- The counters saturate at their terminal values. Extra outputs are impossible by construction; any that occur are a verification failure.
- `start` while `busy` is ignored and does not restart or corrupt the counters.
- `rst` mid-frame forces IDLE immediately and clears the counters and `fresh`. The line buffers are not reset; the next frame overwrites them.

## Timing
- Reset values: `in_ready`=0, `layer_en`=0, `out_valid`=0, `busy`=0, `done`=0, state IDLE.
- `start` → STREAM on the next edge. `in_ready` can be high one cycle after `start`.
- Input-to-output latency: the result computed from the accepted pixel is visible (`out_valid`) in the cycle after its acceptance edge.
- Full throughput is one pixel per cycle when `out_ready`=1.
- The last handshake moves DRAIN → DONE on that edge. `done` is high the following cycle, and IDLE follows one cycle after that.
- Counter widths: $clog2(IMAGE_SIZE²+1) bits for the pixel counter and $clog2(OUT_SIZE²+1) bits for the output counter.

## Configuration
- `CONV_SCHED_PERF_EN`:
  - Defined: adds output `stall_cycles` (32 bits). It counts cycles in STREAM or DRAIN where `out_valid && !out_ready`, clears on `start`, and holds its value after DONE.
  - Undefined: neither the port nor the counter exists.

## Structure
- Package `conv_sched_pkg`:
  - State enum `conv_sched_state_t`.
  - Function `out_dim(image, filter, stride)` used to derive OUT_SIZE.
  - Helper for counter widths.
- Sub-module `frame_counter`: a parameterised up-counter with clear, enable and terminal-count output. It is instantiated twice, once for pixels and once for outputs.

## Test plan
- IMAGE_SIZE=4, FILTER_SIZE=3, STRIDE=1, `in_valid` and `out_ready` held high → 16 `layer_en` pulses, 4 output handshakes, `done` one cycle after the 4th handshake.
- Same configuration with `out_ready` low for 5 cycles while `out_valid`=1 → `in_ready`=0 and `layer_en`=0 throughout, output data stable, no pixel lost; with perf enabled, `stall_cycles`=5.
- IMAGE_SIZE=5, FILTER_SIZE=3, STRIDE=2 → 25 pixels in, exactly 4 outputs, then DONE.
- `start` pulsed mid-STREAM → ignored; counts and the `done` cycle are unchanged from the reference run.
- `rst` asserted after 7 pixels, then `start` → all outputs 0 immediately on reset; the new frame completes with exactly 16 pixels and 4 outputs.
- `in_valid` toggling 1/0 every cycle → 32 cycles of input and correct output ordering; `layer_en` never high while `in_valid`=0.
